// File: rtl/seq_det_pkg.sv
// Shared constants for the parametrised Moore sequence detector.
// Defaults reproduce the legacy fixed "1110" detector with overlap on.
package seq_det_pkg;

  localparam int N_MAX_DEF = 8;
  localparam int CNT_W_DEF = 8;

  function automatic int lw_of(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int LW_DEF = lw_of(N_MAX_DEF);

  localparam logic [N_MAX_DEF-1:0] SEQ_DEF_PATTERN = 8'b0000_1110;
  localparam int                   SEQ_DEF_LEN     = 4;
  localparam bit                   SEQ_DEF_OVERLAP = 1'b1;

  // k is the matched-prefix length; 0 is IDLE, the configured length is DETECT
  typedef logic [LW_DEF-1:0] k_t;
  localparam k_t K_IDLE = '0;

endpackage

// File: rtl/seq_detector_moore_if.sv
// Sample, configuration and status signals of the sequence detector.
interface seq_detector_moore_if #(
  parameter int N_MAX = 8,
  parameter int CNT_W = 8
);
  localparam int LW = $clog2(N_MAX + 1);

  logic             en;
  logic             x;
  logic             cfg_load;
  logic [N_MAX-1:0] cfg_pattern;
  logic [LW-1:0]    cfg_len;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;
  logic             cfg_err;

  modport master (
    output en, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  y, match_count, count_sat, cfg_err
  );

  modport slave (
    input  en, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output y, match_count, count_sat, cfg_err
  );

endinterface

// File: rtl/seq_prefix_match.sv
// Longest pattern prefix that is also a suffix of the sample window.
// hist[0] is the newest bit; pattern is right-aligned with bit len-1 first.
module seq_prefix_match #(
  parameter int N_MAX = 8,
  parameter int LW    = $clog2(N_MAX + 1)
) (
  input  logic [N_MAX-1:0] hist,
  input  logic [LW-1:0]    v,
  input  logic [N_MAX-1:0] pattern,
  input  logic [LW-1:0]    len,
  output logic [LW-1:0]    k_nxt
);

  logic [N_MAX:1] hit;

  // Prefix of length j aligned to the window: pattern >> (len-j), low j bits.
  always_comb begin
    hit = '0;
    for (int j = 1; j <= N_MAX; j++) begin
      if (j <= int'(len) && j <= int'(v)) begin
        hit[j] = (((hist ^ (pattern >> (int'(len) - j))) &
                   ({N_MAX{1'b1}} >> (N_MAX - j))) == '0);
      end
    end
  end

  always_comb begin
    k_nxt = '0;
    for (int j = 1; j <= N_MAX; j++) begin
      if (hit[j]) begin
        k_nxt = LW'(j);
      end
    end
  end

endmodule

// File: rtl/seq_detector_moore.sv
// Run-time configurable Moore sequence detector with saturating match counter.
//   state        | meaning
//   k = 0        | IDLE: no prefix of the pattern matched
//   0 < k < len  | k leading pattern bits matched
//   k = len      | DETECT: y = 1
module seq_detector_moore
  import seq_det_pkg::*;
#(
  parameter int               N_MAX       = N_MAX_DEF,
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [N_MAX-1:0] DEF_PATTERN = N_MAX'(SEQ_DEF_PATTERN),
  parameter int               DEF_LEN     = SEQ_DEF_LEN,
  parameter bit               DEF_OVERLAP = SEQ_DEF_OVERLAP
) (
  input logic                 clk,
  input logic                 rst,
  seq_detector_moore_if.slave bus
);

  localparam int LW = lw_of(N_MAX);

  logic [N_MAX-1:0] pat_q;
  logic [LW-1:0]    len_q;
  logic             ovl_q;

  // Older N_MAX-1 samples; with the incoming x they form the N_MAX-bit window.
  logic [N_MAX-2:0] hist_q, hist_d;
  logic [LW-1:0]    v_q, v_d, v_inc;
  logic [LW-1:0]    k_q, k_d, k_match;
  logic [N_MAX-1:0] win;
  logic             cfg_ok, sample, hit_detect;

  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             sat_q, err_q;

  assign cfg_ok     = (bus.cfg_len != '0) && (int'(bus.cfg_len) <= N_MAX);
  assign sample     = bus.en && !bus.cfg_load;
  assign win        = {hist_q, bus.x};
  assign v_inc      = (int'(v_q) == N_MAX) ? v_q : v_q + 1'b1;
  assign hit_detect = (k_match == len_q);
  assign cnt_inc    = cnt_q + 1'b1;

  seq_prefix_match #(.N_MAX(N_MAX), .LW(LW)) u_match (
    .hist    (win),
    .v       (v_inc),
    .pattern (pat_q),
    .len     (len_q),
    .k_nxt   (k_match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q <= LW'(K_IDLE);
    end else begin
      k_q <= k_d;
    end
  end

  // A load, accepted or not, consumes the cycle; only an accepted one restarts.
  always_comb begin
    k_d    = k_q;
    v_d    = v_q;
    hist_d = hist_q;
    if (bus.cfg_load) begin
      if (cfg_ok) begin
        k_d    = '0;
        v_d    = '0;
        hist_d = '0;
      end
    end else if (bus.en) begin
      k_d    = k_match;
      hist_d = win[N_MAX-2:0];
      v_d    = (hit_detect && !ovl_q) ? '0 : v_inc;
    end
  end

  always_comb begin
    bus.y = (k_q == len_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      v_q    <= '0;
    end else begin
      hist_q <= hist_d;
      v_q    <= v_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= DEF_PATTERN;
      len_q <= LW'(DEF_LEN);
      ovl_q <= DEF_OVERLAP;
      err_q <= 1'b0;
    end else begin
      err_q <= bus.cfg_load && !cfg_ok;
      if (bus.cfg_load && cfg_ok) begin
        pat_q <= bus.cfg_pattern;
        len_q <= bus.cfg_len;
        ovl_q <= bus.cfg_overlap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (sample && hit_detect) begin
      if (!(&cnt_q)) begin
        cnt_q <= cnt_inc;
      end
      if ((&cnt_inc) || (&cnt_q)) begin
        sat_q <= 1'b1;
      end
    end
  end

  assign bus.match_count = cnt_q;
  assign bus.count_sat   = sat_q;
  assign bus.cfg_err     = err_q;

endmodule

// File: doc/seq_detector_moore.md
# seq_detector_moore

Parametrised Moore-type serial sequence detector: the next generation of the fixed 5-state "1110" detector. The pattern, its length and overlap mode are loadable at run time, sampling is gated by an enable, and a saturating match counter is kept. It sits between the serial input conditioner and the status/interrupt logic.

## Interface

- N_MAX, 8: maximum pattern length in bits (2..16).
- CNT_W, 8: match counter width.
- DEF_PATTERN, 8'b0000_1110: pattern after reset (right-aligned).
- DEF_LEN, 4: pattern length after reset.
- DEF_OVERLAP, 1: overlap mode after reset.
- clk  in  1  clock; all sequential logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  sample enable; x is consumed only when en=1.
- x  in  1  serial data bit.
- cfg_load  in  1  single-cycle strobe: load cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  in  N_MAX  pattern, right-aligned; bit cfg_len-1 is received first, bit 0 last.
- cfg_len  in  LW=$clog2(N_MAX+1)  pattern length.
- cfg_overlap  in  1  1 = overlapping matches; 0 = restart after each match.
- cnt_clr  in  1  synchronous clear of match_count and count_sat.
- y  out  1  detect flag (Moore; function of registered state only).
- match_count  out  CNT_W  number of detections, saturating.
- count_sat  out  1  sticky: counter reached all-ones.
- cfg_err  out  1  one-cycle pulse: rejected cfg_load.

## Operation

- State k = matched-prefix length, 0..len. IDLE is k=0, DETECT is k=len, and y=1 exactly in DETECT.
- A history register holds the last N_MAX sampled bits plus a valid count v (0..N_MAX). v increments per sample (saturating) and is cleared on restart.
- Sample (en=1, no cfg_load): shift x into history. Next k = largest j ≤ min(len, v) such that the last j history bits equal the first j pattern bits (pattern[len-1] down to pattern[len-j]).
- Overlap=1: DETECT behaves like any other state, so "1111" with pattern "11" gives DETECT on samples 2, 3 and 4.
- Overlap=0: entering DETECT clears v, so the next sample is matched against the first pattern bit only. "1111" with pattern "11" gives DETECT on samples 2 and 4.
- Default config matches the legacy detector's behaviour: "1110", overlap on.
- en=0: k, history, y and counter all hold.
- cfg_load accepted when 1 ≤ cfg_len ≤ N_MAX:
  - config registers update;
  - k=0, v=0, y=0 next cycle;
  - match_count is preserved.
- cfg_load rejected (cfg_len=0 or cfg_len>N_MAX): config unchanged, state unchanged, cfg_err=1 for one cycle.
- cfg_load and en in the same cycle: load wins and the sample is discarded. A rejected load also discards the sample.
- Counter increments on each sample whose next state is DETECT, including DETECT→DETECT in overlap mode.
  - At all-ones it holds and sets count_sat; count_sat stays set until cnt_clr.
- cnt_clr and an increment in the same cycle: clear wins, giving 0 and count_sat=0.
- Pattern bits above len-1 are ignored.

## Timing

- Reset values:
  - k=0, v=0, y=0, match_count=0, count_sat=0, cfg_err=0;
  - config = DEF_PATTERN, DEF_LEN, DEF_OVERLAP.
- Reset assertion clears everything immediately, including mid-pattern. Deassertion is synchronised by the system; the first sample is taken on the first rising edge with rst=1.
- Latency: the final pattern bit is sampled at edge t. y=1 and match_count is updated after edge t, and both hold until the next sampling edge.
- y is glitch-free (registered state decode), with no combinational path from x to y.
- cfg_err asserts the cycle after the rejected strobe.

## Structure

- Package seq_det_pkg holds:
  - LW computation;
  - default pattern/length/overlap constants;
  - the k state encoding (width LW).
- Sub-module seq_prefix_match (combinational): takes history, v, pattern and len, and returns next k via a parallel compare over j=N_MAX..1 with a priority select.
- Top level holds the config registers, history/v/k registers, counter and cfg_err.

## Test plan

- Reset defaults, overlap on: x = 1,1,1,1,0 → y=1 only after the 5th sample; match_count=1.
- Load pattern "11" (len=2) with overlap=0, then x = 1,1,1,1 → y high after samples 2 and 4; count=2. Repeat with overlap=1 → y high after samples 2, 3 and 4; count=3.
- Load len=0 and len=N_MAX+1 → cfg_err pulses, and the old pattern still detects "1110". Load together with en=1 → that sample is ignored and k=0.
- en toggled mid-pattern: "11", en=0 for 3 cycles with x=0, then "10" → a single detect; y holds while en=0.
- CNT_W=3: 8 matches → count=7 and count_sat=1; cnt_clr together with a match → count=0 and count_sat=0.
- Assert rst while k=3 of "1110": y, count and k all go to 0 immediately. After release, x=0 does not detect.
